upe_negate64: RTL and testbench
===============================

# upe_negate64

Registered 64-bit negation unit for the uncertainty-propagation datapath. Takes one operand per cycle, applies the selected negation (bitwise one's complement by default, optionally two's complement or IEEE-754 sign flip), and presents the result one clock later with a valid flag and status flags. It sits between operand registers and the downstream arithmetic stages, and also drives the LED bit-serial display path on the iCE40 build. The iCE40 build clocks it from the SB_LFOSC 10 kHz low-frequency oscillator.

## Interface
- WIDTH, 64: operand width in bits; must be at least 2.
- clk  input  1  sole clock, rising edge; on iCE40 driven by SB_LFOSC CLKLF (10 kHz).
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand on In is accepted this cycle.
- mode  input  2  operation select: 00 one's complement, 01 two's complement, 10 sign-bit flip, 11 pass-through.
- In  input  WIDTH  operand.
- out_valid  output  1  Out and flags hold a fresh result.
- Out  output  WIDTH  result.
- ovf  output  1  two's-complement overflow; set when the operand is the most-negative value (MSB=1, other bits 0).
- zero  output  1  Out is all zeros.

## Operation
- mode 00: Out = ~In (every bit inverted).
- mode 01: Out = ~In + 1, modulo 2^WIDTH, with carry discarded.
- mode 10: Out = In with bit WIDTH-1 inverted and all other bits unchanged.
- mode 11: Out = In.
- ovf is only asserted in mode 01, when In = 1 followed by WIDTH-1 zeros; Out then equals In. ovf is 0 in every other mode.
- zero = (Out == 0), computed on the registered result. Mode 01 with In = 0 gives Out = 0, zero = 1, ovf = 0.
- No backpressure: a result is produced for every accepted operand. When in_valid is low, Out, ovf and zero hold their values and out_valid drops to 0.
- Operands are treated as unsigned bit patterns. Arithmetic meaning comes only from the mode.

## Timing
- Latency is exactly 1 cycle. When in_valid is high at edge N, Out, ovf, zero and out_valid are updated after edge N.
- Throughput is one operand per cycle, and back-to-back operands are allowed.
- mode is sampled together with In at the same edge.
- Reset values: Out = 0, out_valid = 0, ovf = 0, zero = 1. Reset takes effect immediately and asynchronously.
- If rst is asserted during operation, any in-flight result is discarded. The first valid operand after rst deasserts produces out_valid one cycle later.
- All outputs are driven directly from registers, with no combinational path from inputs to outputs.

## Configuration
- UPE_NEGATE_TWOS_EN: when defined, mode 01 (two's complement) is built, including the incrementer and the ovf detection.
- When the macro is undefined, mode 01 behaves identically to mode 00, ovf is tied to 0, and no adder is synthesized.

## Structure
- A shared package, upe_pkg, holds:
  - the mode encoding constants (UPE_NEG_ONES, UPE_NEG_TWOS, UPE_NEG_SIGN, UPE_NEG_PASS);
  - the default WIDTH value of 64.
- The only natural sub-module is upe_negate_core: a purely combinational function of mode and In that produces the next Out value and the ovf condition.
- The top level adds the registers, the valid pipeline and zero detection.
- The incrementer lives inside the core and is guarded by UPE_NEGATE_TWOS_EN.

## Test plan
- Reset: assert rst mid-stream -> Out = 0, out_valid = 0, zero = 1, ovf = 0 immediately, without waiting for a clock edge.
- mode 00, In = 64'hA32AEACECB2AEACE -> one cycle later Out = 64'h5CD5153134D51531, out_valid = 1, zero = 0.
- mode 01 (macro defined), In = 64'hA32AEACECB2AEACE -> Out = 64'h5CD5153134D51532.
- mode 01 boundary cases:
  - In = 64'h8000000000000000 -> Out = 64'h8000000000000000, ovf = 1.
  - In = 0 -> Out = 0, zero = 1, ovf = 0.
- mode 10, In = 64'hA32AEACECB2AEACE -> Out = 64'h232AEACECB2AEACE. mode 11 with the same In -> Out equals In.
- Streaming: apply mode 00 for In = 0, then In = all-ones, on consecutive cycles, then drop in_valid -> Out = all-ones, then 0, then held at 0. out_valid = 1, 1, then 0.

Source files
------------

// File: rtl/upe_pkg.sv
// Shared definitions for the uncertainty-propagation negation datapath.
//   UPE_NEG_* : 2-bit operation-select encodings for the negation unit
//   UPE_WIDTH : default operand width
package upe_pkg;

   localparam int unsigned UPE_WIDTH = 64;

   localparam logic [1:0] UPE_NEG_ONES = 2'b00;  // bitwise inversion
   localparam logic [1:0] UPE_NEG_TWOS = 2'b01;  // two's complement
   localparam logic [1:0] UPE_NEG_SIGN = 2'b10;  // IEEE-754 sign flip
   localparam logic [1:0] UPE_NEG_PASS = 2'b11;  // pass-through

endpackage : upe_pkg

// File: rtl/upe_negate_core.sv
// Combinational negation core: next result value and overflow condition.
// Build option: UPE_NEGATE_TWOS_EN builds the incrementer and overflow detect;
// without it, two's-complement mode falls back to bitwise inversion.
// Ports:
//   mode     : operation select (upe_pkg UPE_NEG_* encodings)
//   operand  : input operand
//   result_c : negated value
//   ovf_c    : operand is the most-negative value in two's-complement mode
module upe_negate_core
   import upe_pkg::*;
#(
   parameter int unsigned WIDTH = UPE_WIDTH
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] result_c,
   output logic             ovf_c
);

   // MSB alone set: the sign-flip mask and the only two's-complement overflow pattern
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   // Operation select
   always_comb begin
      result_c = operand;
      ovf_c    = 1'b0;
      case (mode)
         UPE_NEG_ONES: result_c = ~operand;
         UPE_NEG_TWOS: begin
`ifdef UPE_NEGATE_TWOS_EN
            result_c = ~operand + WIDTH'(1);
            ovf_c    = (operand == SIGN_MASK);
`else
            result_c = ~operand;
`endif
         end
         UPE_NEG_SIGN: result_c = operand ^ SIGN_MASK;
         UPE_NEG_PASS: result_c = operand;
         default:      result_c = operand;
      endcase
   end

endmodule : upe_negate_core

// File: rtl/upe_negate64.sv
// Registered 64-bit negation unit, one-cycle latency, one operand per cycle.
// Build option: UPE_NEGATE_TWOS_EN enables two's-complement mode and ovf.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   in_valid  : operand accepted this cycle
//   mode      : operation select (upe_pkg UPE_NEG_* encodings)
//   In        : operand
//   out_valid : Out/flags hold a fresh result
//   Out       : result (held while no operand is accepted)
//   ovf       : two's-complement overflow (most-negative operand)
//   zero      : Out is all zeros
module upe_negate64
   import upe_pkg::*;
#(
   parameter int unsigned WIDTH = UPE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] In,
   output logic             out_valid,
   output logic [WIDTH-1:0] Out,
   output logic             ovf,
   output logic             zero
);

   logic [WIDTH-1:0] result_c;
   logic             ovf_c;

   upe_negate_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .mode     (mode),
      .operand  (In),
      .result_c (result_c),
      .ovf_c    (ovf_c)
   );

   // Result registers; zero is taken from the value being registered so it
   // always describes the current Out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         Out       <= '0;
         ovf       <= 1'b0;
         zero      <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Out  <= result_c;
            ovf  <= ovf_c;
            zero <= (result_c == '0);
         end
      end
   end

endmodule : upe_negate64

// File: tb/tb_upe_negate64.sv
// Scoreboard bench for upe_negate64: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_upe_negate64;

   localparam int unsigned W = 64;

   typedef struct {
      logic [W-1:0] out;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [1:0]   mode;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         ovf;
   logic         zero;

   exp_t sb_q[$];
   int   tests;
   int   fails;
   int   pushed;
   int   popped;

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] PAT  = 64'hA32AEACECB2AEACE;
   localparam logic [W-1:0] MINN = 64'h8000000000000000;

   upe_negate64 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .In        (in_data),
      .out_valid (out_valid),
      .Out       (out_data),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one operand at the falling edge and record its expected result.
   task automatic send(input logic [1:0] m, input logic [W-1:0] d,
                       input logic [W-1:0] exp_out, input logic exp_ovf);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      mode     = m;
      in_data  = d;
      e.out    = exp_out;
      e.ovf    = exp_ovf;
      e.zero   = (exp_out == '0);
      sb_q.push_back(e);
      pushed++;
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: got result %h, expected none", out_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            popped++;
            check("result_out",  out_data, e.out);
            check("result_ovf",  W'(ovf),  W'(e.ovf));
            check("result_zero", W'(zero), W'(e.zero));
         end
      end
   end

   initial begin
      tests = 0; fails = 0; pushed = 0; popped = 0;
      rst = 1'b1; in_valid = 1'b0; mode = 2'b00; in_data = '0;
      #1;
      check("rst_out",       out_data,       '0);
      check("rst_out_valid", W'(out_valid),  W'(0));
      check("rst_ovf",       W'(ovf),        W'(0));
      check("rst_zero",      W'(zero),       W'(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors, back to back
      send(2'b00, PAT,  64'h5CD5153134D51531, 1'b0);
`ifdef UPE_NEGATE_TWOS_EN
      send(2'b01, PAT,  64'h5CD5153134D51532, 1'b0);
      send(2'b01, MINN, MINN,                 1'b1);
      send(2'b01, '0,   '0,                   1'b0);
      send(2'b01, ONES, 64'h0000000000000001, 1'b0);
`else
      send(2'b01, PAT,  64'h5CD5153134D51531, 1'b0);
      send(2'b01, MINN, 64'h7FFFFFFFFFFFFFFF, 1'b0);
      send(2'b01, '0,   ONES,                 1'b0);
      send(2'b01, ONES, '0,                   1'b0);
`endif
      send(2'b10, PAT,  64'h232AEACECB2AEACE, 1'b0);
      send(2'b10, MINN, '0,                   1'b0);
      send(2'b11, PAT,  PAT,                  1'b0);
      send(2'b11, '0,   '0,                   1'b0);
      send(2'b00, ONES, '0,                   1'b0);

      // Streaming then drop in_valid: results held, out_valid falls
      send(2'b00, '0,   ONES, 1'b0);
      send(2'b00, ONES, '0,   1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = PAT;
      @(negedge clk);
      check("hold_out_valid", W'(out_valid), W'(0));
      check("hold_out",       out_data,      '0);
      check("hold_zero",      W'(zero),      W'(1));
      @(negedge clk);
      check("hold2_out",      out_data,      '0);

      // Mid-stream asynchronous reset discards the in-flight result
      send(2'b00, '0, ONES, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      void'(sb_q.pop_back());
      pushed--;
      #1;
      check("async_rst_out",       out_data,      '0);
      check("async_rst_out_valid", W'(out_valid), W'(0));
      check("async_rst_zero",      W'(zero),      W'(1));
      check("async_rst_ovf",       W'(ovf),       W'(0));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // First operand after reset
      send(2'b10, '0, MINN, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sb_empty",     W'(sb_q.size()), W'(0));
      check("sb_all_seen",  W'(popped),      W'(pushed));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_upe_negate64
